instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch front end for the 64-bit RISC-V core. It holds the fetch PC and drives the address port of the combinational instruction memory. It captures each returned 32-bit word, together with its PC, into a small prefetch queue and presents the queue head to decode over a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the target.

## Interface
- RESET_PC, 64'h0: fetch PC after reset; bits [1:0] must be 0.
- QUEUE_DEPTH, 4: prefetch queue entries; power of two, ≥2.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- imem_addr, output, 64: byte address to instruction memory; equals fetch_pc register.
- imem_instr, input, 32: instruction word at imem_addr; valid combinationally in the same cycle.
- fetch_en, input, 1: when 0, no new words are captured; queue drains normally.
- redirect_valid, input, 1: flush queue and restart fetch at redirect_pc.
- redirect_pc, input, 64: redirect target; bits [1:0] forced to 0 internally.
- out_valid, output, 1: queue head is valid.
- out_ready, input, 1: decode accepts head this cycle.
- out_instr, output, 32: head instruction; 32'h00000013 (NOP) when queue empty.
- out_pc, output, 64: PC of head instruction; 64'h0 when queue empty.
- occupancy, output, $clog2(QUEUE_DEPTH+1): number of valid queue entries.

## Operation
- State: fetch_pc (64), circular queue of {pc[63:0], instr[31:0]}, rd_ptr, wr_ptr, count.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < QUEUE_DEPTH | pop).
- Push: writes {fetch_pc, imem_instr} at wr_ptr; wr_ptr+1; fetch_pc <= fetch_pc + 4 (mod 2^64, wraps to 0).
- Pop: rd_ptr+1. count updates as count + push − pop. Push and pop in the same cycle when full is legal and leaves count at QUEUE_DEPTH.
- Pointers wrap modulo QUEUE_DEPTH.
- Redirect has priority over push and pop. On the edge:
  - count, rd_ptr and wr_ptr go to 0.
  - fetch_pc <= {redirect_pc[63:2], 2'b00}.
  - No word is captured that cycle.
  - A handshake completing in the redirect cycle is still a valid transfer for decode; the queue is flushed regardless.
- fetch_en=0: fetch_pc holds, no push; redirect is still honoured.
- out_valid = (count != 0). out_instr and out_pc come combinationally from entry rd_ptr when valid, otherwise NOP and 0.
- Decode must not see out_valid drop without a pop, except on redirect or reset.

## Timing
- Reset (asynchronous assert, any cycle, including mid-stream):
  - fetch_pc = RESET_PC, so imem_addr = RESET_PC.
  - count = 0, out_valid = 0, out_instr = 32'h00000013, out_pc = 0, occupancy = 0.
- Fetch to output: a word captured at edge N appears as head at cycle N+1 if the queue was empty, giving 1-cycle latency.
- Redirect to first target instruction:
  - redirect_valid high in cycle N.
  - imem_addr = target in cycle N+1.
  - out_valid = 1 with out_pc = target in cycle N+2.
- Steady state with out_ready held high: one instruction per cycle, sequential PCs.
- Full queue with out_ready=0: imem_addr holds; no word is dropped or duplicated.
- Back-to-back redirects: the last one wins; each flush discards the previous target's captured words.

## Test plan
- Reset release, RESET_PC=0, out_ready=1, fetch_en=1 -> out_pc sequence 0,4,8,…; out_instr matches memory words 0,1,2,…; out_valid first high 1 cycle after release.
- out_ready=0 for 10 cycles -> occupancy saturates at 4; imem_addr holds at 0x10. Then out_ready=1 -> PCs 0x0..0x1C delivered in order with no gap.
- Redirect to 0x20 while the queue holds 3 entries -> occupancy 0 next cycle; out_valid=1 with out_pc=0x20 two cycles after redirect.
- Redirect to 0x23 -> fetch restarts at 0x20.
- Redirect in the same cycle as a full-queue push/pop -> redirect wins; no stale PC appears afterwards.
- fetch_en=0 mid-stream -> queue drains to empty; out_instr=0x00000013, out_pc=0.
- rst_n pulsed low mid-stream -> all outputs at reset values asynchronously; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front end.
// Holds the fetch PC and drives a combinational instruction memory.
// Each returned word is captured into a circular prefetch queue together
// with its PC. The queue head goes to decode over a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at the target.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   imem_addr       fetch PC driven to instruction memory
//   imem_instr      word at imem_addr, same cycle
//   fetch_en        capture enable (queue still drains when low)
//   redirect_valid  flush + restart at redirect_pc (word aligned internally)
//   out_valid/ready head handshake; out_instr/out_pc = head, NOP/0 when empty
//   occupancy       valid entries in the queue
module instr_fetch #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [63:0]                      imem_addr,
  input  logic [31:0]                      imem_instr,
  input  logic                             fetch_en,
  input  logic                             redirect_valid,
  input  logic [63:0]                      redirect_pc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [31:0]                      out_instr,
  output logic [63:0]                      out_pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          q [QUEUE_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [63:0]     fetch_pc;
  logic            full, push, pop;

  assign full = (count == CW'(QUEUE_DEPTH));
  assign pop  = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full queue still accepts a word.
  assign push = fetch_en & ~redirect_valid & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // Flush wins over push/pop; a same-cycle handshake already delivered.
      fetch_pc <= {redirect_pc[63:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible below count.
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr};
  end

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? q[rd_ptr].instr : NOP;
  assign out_pc    = out_valid ? q[rd_ptr].pc    : 64'h0;
  assign occupancy = count;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a queue-level reference model.
module tb_instr_fetch;
  localparam int          D   = 4;
  localparam logic [63:0] RPC = 64'h0;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 0;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_en, redirect_valid, out_ready;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [$clog2(D+1)-1:0] occupancy;

  int n_cmp = 0, n_err = 0;

  // reference: fetch PC plus a queue of captured PCs (words are a pure function of PC)
  logic [63:0] mpc;
  logic [63:0] mq[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[33:2] * 32'h9E3779B1) ^ 32'h5A5A0000 ^ a[63:32];
  endfunction

  assign imem_instr = mem(imem_addr);

  instr_fetch #(.RESET_PC(RPC), .QUEUE_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_model();
    int n = mq.size();
    chk("imem_addr", imem_addr, mpc);
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("occupancy", 64'(occupancy), 64'(n));
    chk("out_pc", out_pc, n != 0 ? mq[0] : 64'h0);
    chk("out_instr", 64'(out_instr), 64'(n != 0 ? mem(mq[0]) : NOP));
  endtask

  // one cycle: drive at negedge, check, then step the model on the edge
  task automatic cyc(input logic fe, input logic rv, input logic [63:0] rpc, input logic rdy);
    int  n;
    logic pop, push;
    @(negedge clk);
    fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1 chk_model();
    @(posedge clk);
    n    = mq.size();
    pop  = (n != 0) && rdy;
    push = fe && !rv && (n < D || pop);
    if (rv) begin
      mq.delete();
      mpc = {rpc[63:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin mq.push_back(mpc); mpc = mpc + 64'd4; end
    end
  endtask

  // settle after the edge just taken; inputs are unchanged until next negedge
  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'(NOP));
    chk("rst_pc", out_pc, 64'h0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    mq.delete();
    mpc = RPC;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0; fetch_en = 0; redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    mpc = RPC;
    #3;
    do_reset();

    // streaming from reset
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1);

    // stall fills the queue; fetch PC parks at 0x10
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
    settle();
    chk("stall_occ", 64'(occupancy), 64'd4);
    chk("stall_addr", imem_addr, 64'h10);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1);

    // redirect with 3 queued entries
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 64'h20, 0);
    settle();
    chk("redir_occ", 64'(occupancy), 64'd0);
    chk("redir_addr", imem_addr, 64'h20);
    cyc(1, 0, 0, 0);
    settle();
    chk("redir_head", out_pc, 64'h20);

    // misaligned target is word aligned
    cyc(1, 1, 64'h23, 1);
    settle();
    chk("align_addr", imem_addr, 64'h20);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);

    // redirect during full push/pop
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 64'h100, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);

    // back-to-back redirects, last wins
    cyc(1, 1, 64'h200, 1);
    cyc(1, 1, 64'h300, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);

    // fetch disabled: drain to empty
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
    settle();
    chk("drain_instr", 64'(out_instr), 64'(NOP));
    chk("drain_pc", out_pc, 64'h0);

    // PC wraps past 2^64
    cyc(1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1);

    // mid-stream reset
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc(($urandom % 8) != 0, ($urandom % 12) == 0,
          {$urandom, $urandom}, ($urandom % 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
